// File: rtl/miner_pkg.sv
// Shared types and helpers for the multi-core nonce dispatcher.
package miner_pkg;

    localparam int unsigned MAX_CORES   = 16;
    localparam int unsigned MAX_IDX_W   = 4;
    localparam int unsigned MAX_NONCE_W = 256;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    // Result entry sized for the widest supported configuration.
    typedef struct packed {
        logic [MAX_NONCE_W-1:0] nonce;
        logic [MAX_IDX_W-1:0]   core;
    } res_t;

    // Returns {found, index} of the first set req bit at or after start, wrapping at n.
    function automatic logic [MAX_IDX_W:0] rr_pick(input logic [MAX_CORES-1:0] req,
                                                   input logic [MAX_IDX_W-1:0] start,
                                                   input int unsigned n);
        int unsigned idx;
        rr_pick = '0;
        for (int k = MAX_CORES - 1; k >= 0; k--) begin
            if (k < int'(n)) begin
                idx = (32'(start) + 32'(k)) % n;
                if (req[idx[MAX_IDX_W-1:0]]) begin
                    rr_pick = {1'b1, idx[MAX_IDX_W-1:0]};
                end
            end
        end
    endfunction

endpackage

// File: rtl/miner_res_fifo.sv
// Result FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module miner_res_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/miner_nonce_dispatcher.sv
// Multi-core nonce dispatcher: round-robin nonce issue to idle cores and queueing
// of winning nonces for the host.
module miner_nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int unsigned CORES     = 4,
    parameter int unsigned NONCE_W   = 192,
    parameter int unsigned CNT_W     = 64,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start_I,
    input  logic                     Stop_I,
    input  logic                     StopOnFound_I,
    input  logic [NONCE_W-1:0]       NonceBase_I,
    input  logic [CNT_W-1:0]         Limit_I,
    output logic [CORES-1:0]         CoreUpdate_O,
    output logic [NONCE_W-1:0]       Nonce_O,
    input  logic [CORES-1:0]         CoreDone_I,
    input  logic [CORES-1:0]         CoreFound_I,
    output logic                     ResVld_O,
    output logic [NONCE_W-1:0]       ResNonce_O,
    output logic [$clog2(CORES)-1:0] ResCore_O,
    input  logic                     ResRdy_I,
    output logic                     Busy_O,
    output logic [CNT_W-1:0]         Issued_O,
    output logic                     Overflow_O
);

    localparam int unsigned IDX_W = $clog2(CORES);

    state_e             state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_out_q;
    logic [NONCE_W-1:0] slot_q [CORES];
    logic [CNT_W-1:0]   limit_q, issued_q;
    logic [CORES-1:0]   busy_q, pend_q, upd_q;
    logic [IDX_W-1:0]   iss_ptr_q, pend_ptr_q;
    logic               push_q, ovf_q;
    res_t               push_data_q, head;

    logic [CORES-1:0]   done_v, found_v, iss_oh, pend_oh;
    logic [MAX_IDX_W:0] iss_pick, pend_pick;
    logic [IDX_W-1:0]   iss_idx, pend_idx;
    logic               limit_hit, run_exit, do_issue, pend_sel, res_pop;
    logic               fifo_empty, fifo_full;

    always_comb begin
        done_v    = CoreDone_I & busy_q;
        found_v   = done_v & CoreFound_I;
        limit_hit = (limit_q != '0) && (issued_q == limit_q);
        run_exit  = Stop_I || limit_hit || (StopOnFound_I && (|found_v));
        // Pointers hold the first candidate of the next search.
        iss_pick  = rr_pick(MAX_CORES'(~busy_q & ~pend_q), MAX_IDX_W'(iss_ptr_q), CORES);
        pend_pick = rr_pick(MAX_CORES'(pend_q), MAX_IDX_W'(pend_ptr_q), CORES);
        iss_idx   = iss_pick[IDX_W-1:0];
        pend_idx  = pend_pick[IDX_W-1:0];
        do_issue  = (state_q == StRun) && !run_exit && iss_pick[MAX_IDX_W];
        pend_sel  = pend_pick[MAX_IDX_W];
        iss_oh    = do_issue ? (CORES'(1) << iss_idx) : '0;
        pend_oh   = pend_sel ? (CORES'(1) << pend_idx) : '0;
        res_pop   = !fifo_empty && ResRdy_I;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Start_I) state_d = StRun;
            StRun:   if (run_exit) state_d = StDrain;
            StDrain: if ((busy_q == '0) && (pend_q == '0)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= StIdle;
            nonce_q     <= '0;
            nonce_out_q <= '0;
            for (int i = 0; i < int'(CORES); i++) begin
                slot_q[i] <= '0;
            end
            limit_q     <= '0;
            issued_q    <= '0;
            busy_q      <= '0;
            pend_q      <= '0;
            upd_q       <= '0;
            iss_ptr_q   <= '0;
            pend_ptr_q  <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            upd_q   <= iss_oh;
            push_q  <= pend_sel;
            if (pend_sel) begin
                push_data_q.nonce <= MAX_NONCE_W'(slot_q[pend_idx]);
                push_data_q.core  <= MAX_IDX_W'(pend_idx);
                pend_ptr_q        <= (32'(pend_idx) == CORES - 1) ? '0 : pend_idx + 1'b1;
            end
            if (push_q && fifo_full && !res_pop) begin
                ovf_q <= 1'b1;
            end
            if ((state_q == StIdle) && Start_I) begin
                nonce_q  <= NonceBase_I;
                limit_q  <= Limit_I;
                issued_q <= '0;
                busy_q   <= '0;
                pend_q   <= '0;
            end else begin
                busy_q <= (busy_q & ~done_v) | iss_oh;
                pend_q <= (pend_q | found_v) & ~pend_oh;
            end
            if (do_issue) begin
                nonce_out_q     <= nonce_q;
                slot_q[iss_idx] <= nonce_q;
                nonce_q         <= {nonce_q[NONCE_W-1:CNT_W], nonce_q[CNT_W-1:0] + 1'b1};
                issued_q        <= issued_q + 1'b1;
                iss_ptr_q       <= (32'(iss_idx) == CORES - 1) ? '0 : iss_idx + 1'b1;
            end
        end
    end

    miner_res_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .push    (push_q),
        .wr_data (push_data_q),
        .pop     (res_pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign CoreUpdate_O = upd_q;
    assign Nonce_O      = nonce_out_q;
    assign ResVld_O     = !fifo_empty;
    assign ResNonce_O   = head.nonce[NONCE_W-1:0];
    assign ResCore_O    = head.core[IDX_W-1:0];
    assign Busy_O       = (state_q != StIdle);
    assign Issued_O     = issued_q;
    assign Overflow_O   = ovf_q;

endmodule
